branch_resolve_ctrl: RTL and testbench

//  Sequences branch-unit results into frontend recovery and predictor training.
//  - Picks the oldest outstanding mispredict by ROB age.
//  - Drives a redirect/flush handshake through a small FSM.
//  - Buffers predictor updates (BTB/BHT) in a FIFO.
//  - Sits between the execute-stage branch unit and fetch/ROB/predictor.

---
 rtl/branch_pkg.sv | 31 +++
 rtl/branch_update_fifo.sv | 52 +++++
 rtl/branch_resolve_ctrl.sv | 168 ++++++++++++++++
 tb/tb_branch_resolve_ctrl.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_pkg.sv
// Shared types for the branch resolve controller: FSM states, predictor update record, ROB age helper.
package branch_pkg;

    localparam int BR_ADDR_W    = 32;
    localparam int BR_ROB_W_MAX = 8;

    typedef enum logic [1:0] {
        IDLE,
        REDIRECT,
        RECOVER
    } brc_state_e;

    typedef struct packed {
        logic [BR_ADDR_W-1:0] pc;
        logic [BR_ADDR_W-1:0] target;
        logic                 taken;
        logic                 is_jump;
    } br_update_t;

    // Distance from the ROB head, modulo the ROB depth; smaller means older.
    function automatic logic [BR_ROB_W_MAX-1:0] rob_age(
        input logic [BR_ROB_W_MAX-1:0] idx,
        input logic [BR_ROB_W_MAX-1:0] head,
        input int unsigned             width
    );
        logic [BR_ROB_W_MAX-1:0] mask;
        mask = BR_ROB_W_MAX'((1 << width) - 1);
        return (idx - head) & mask;
    endfunction

endpackage

// File: rtl/branch_update_fifo.sv
// Predictor-update FIFO: power-of-2 depth, valid/ready head, registered occupancy count.
module branch_update_fifo
    import branch_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  br_update_t       push_data,
    output logic             out_valid,
    input  logic             out_ready,
    output br_update_t       out_data,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);

    br_update_t       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign out_valid = (count != '0);
    assign out_data  = mem[rd_ptr];
    assign do_pop    = out_valid && out_ready;
    assign do_push   = push && (count < CNT_W'(DEPTH));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Payload storage carries no reset; validity comes from count.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/branch_resolve_ctrl.sv
// Branch resolve controller: oldest-mispredict redirect/flush sequencing plus predictor update buffering.
// Optional perf counters are built when BRANCH_STATS_EN is defined.
//   state    | meaning
//   IDLE     | no recovery in progress
//   REDIRECT | redirect to fetch pending handshake
//   RECOVER  | post-flush window, wrong-path results dropped
module branch_resolve_ctrl
    import branch_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int ROB_IDX_W      = 5,
    parameter int UPD_DEPTH      = 4,
    parameter int RECOVER_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  br_valid,
    output logic                  br_ready,
    input  logic [ROB_IDX_W-1:0]  br_rob_idx,
    input  logic [ADDR_WIDTH-1:0] br_pc,
    input  logic                  br_mispredict,
    input  logic                  br_actual_taken,
    input  logic [ADDR_WIDTH-1:0] br_actual_target,
    input  logic                  br_is_jump,
    input  logic [ROB_IDX_W-1:0]  rob_head_idx,
    output logic                  redirect_valid,
    input  logic                  redirect_ready,
    output logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  flush_valid,
    output logic [ROB_IDX_W-1:0]  flush_rob_idx,
    output logic                  upd_valid,
    input  logic                  upd_ready,
    output logic [ADDR_WIDTH-1:0] upd_pc,
    output logic [ADDR_WIDTH-1:0] upd_target,
    output logic                  upd_taken,
    output logic                  upd_is_jump,
    output logic [31:0]           stat_branches,
    output logic [31:0]           stat_mispredicts
);

    localparam int CNT_W = $clog2(UPD_DEPTH) + 1;
    localparam int RC_W  = $clog2(RECOVER_CYCLES + 1);

    brc_state_e              state_q, state_d;
    logic [ROB_IDX_W-1:0]    pend_idx_q, pend_idx_d;
    logic [ADDR_WIDTH-1:0]   pend_pc_q, pend_pc_d;
    logic [ROB_IDX_W-1:0]    flush_idx_q, flush_idx_d;
    logic                    flush_q, flush_d;
    logic [RC_W-1:0]         rec_cnt_q, rec_cnt_d;
    logic [CNT_W-1:0]        fifo_count;
    br_update_t              upd_in, upd_head;
    logic                    accept, drop, keep, take_mp, handshake;
    logic [BR_ROB_W_MAX-1:0] age_br, age_pend, age_flush;

    assign br_ready  = (fifo_count < CNT_W'(UPD_DEPTH));
    assign accept    = br_valid && br_ready;

    assign age_br    = rob_age(BR_ROB_W_MAX'(br_rob_idx),  BR_ROB_W_MAX'(rob_head_idx), ROB_IDX_W);
    assign age_pend  = rob_age(BR_ROB_W_MAX'(pend_idx_q),  BR_ROB_W_MAX'(rob_head_idx), ROB_IDX_W);
    assign age_flush = rob_age(BR_ROB_W_MAX'(flush_idx_q), BR_ROB_W_MAX'(rob_head_idx), ROB_IDX_W);

    // Anything not strictly older than the branch being recovered is on the wrong path.
    assign drop    = ((state_q != IDLE) && (age_br >= age_pend)) ||
                     ((state_q == RECOVER) && (age_br >= age_flush));
    assign keep    = accept && !drop;
    assign take_mp = keep && br_mispredict;

    assign redirect_valid = (state_q == REDIRECT);
    assign redirect_pc    = redirect_valid ? pend_pc_q : '0;
    assign handshake      = redirect_valid && redirect_ready;
    assign flush_valid    = flush_q;
    assign flush_rob_idx  = flush_idx_q;

    assign upd_in.pc      = BR_ADDR_W'(br_pc);
    assign upd_in.target  = BR_ADDR_W'(br_actual_target);
    assign upd_in.taken   = br_actual_taken;
    assign upd_in.is_jump = br_is_jump;

    branch_update_fifo #(
        .DEPTH (UPD_DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (keep),
        .push_data (upd_in),
        .out_valid (upd_valid),
        .out_ready (upd_ready),
        .out_data  (upd_head),
        .count     (fifo_count)
    );

    assign upd_pc      = ADDR_WIDTH'(upd_head.pc);
    assign upd_target  = ADDR_WIDTH'(upd_head.target);
    assign upd_taken   = upd_head.taken;
    assign upd_is_jump = upd_head.is_jump;

    always_comb begin
        state_d     = state_q;
        pend_idx_d  = pend_idx_q;
        pend_pc_d   = pend_pc_q;
        flush_idx_d = flush_idx_q;
        flush_d     = 1'b0;
        rec_cnt_d   = rec_cnt_q;
        case (state_q)
            IDLE: ;
            REDIRECT: begin
                if (handshake) begin
                    flush_d     = 1'b1;
                    flush_idx_d = pend_idx_q;
                    rec_cnt_d   = RC_W'(RECOVER_CYCLES);
                    state_d     = RECOVER;
                end
            end
            RECOVER: begin
                rec_cnt_d = rec_cnt_q - RC_W'(1);
                if (rec_cnt_q == RC_W'(1)) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // A surviving mispredict is by construction older than any pending one, so it always wins.
        if (take_mp) begin
            pend_idx_d = br_rob_idx;
            pend_pc_d  = br_actual_target;
            state_d    = REDIRECT;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            pend_idx_q  <= '0;
            pend_pc_q   <= '0;
            flush_idx_q <= '0;
            flush_q     <= 1'b0;
            rec_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            pend_idx_q  <= pend_idx_d;
            pend_pc_q   <= pend_pc_d;
            flush_idx_q <= flush_idx_d;
            flush_q     <= flush_d;
            rec_cnt_q   <= rec_cnt_d;
        end
    end

`ifdef BRANCH_STATS_EN
    logic [31:0] stat_br_q;
    logic [31:0] stat_mp_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_br_q <= '0;
            stat_mp_q <= '0;
        end else begin
            if (keep)    stat_br_q <= stat_br_q + 32'd1;
            if (take_mp) stat_mp_q <= stat_mp_q + 32'd1;
        end
    end

    assign stat_branches    = stat_br_q;
    assign stat_mispredicts = stat_mp_q;
`else
    assign stat_branches    = '0;
    assign stat_mispredicts = '0;
`endif

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Bench for branch_resolve_ctrl: directed vector table, hand sequences, randomized run against a queue-based model.
module tb_branch_resolve_ctrl;

    localparam int AW    = 32;
    localparam int RW    = 5;
    localparam int DEPTH = 4;
    localparam int RC    = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          br_valid, br_ready, br_mispredict, br_actual_taken, br_is_jump;
    logic [RW-1:0] br_rob_idx, rob_head_idx, flush_rob_idx;
    logic [AW-1:0] br_pc, br_actual_target, redirect_pc, upd_pc, upd_target;
    logic          redirect_valid, redirect_ready, flush_valid;
    logic          upd_valid, upd_ready, upd_taken, upd_is_jump;
    logic [31:0]   stat_branches, stat_mispredicts;

    always #5 clk = ~clk;

    branch_resolve_ctrl #(
        .ADDR_WIDTH(AW), .ROB_IDX_W(RW), .UPD_DEPTH(DEPTH), .RECOVER_CYCLES(RC)
    ) dut (
        .clk(clk), .rst(rst),
        .br_valid(br_valid), .br_ready(br_ready), .br_rob_idx(br_rob_idx), .br_pc(br_pc),
        .br_mispredict(br_mispredict), .br_actual_taken(br_actual_taken),
        .br_actual_target(br_actual_target), .br_is_jump(br_is_jump),
        .rob_head_idx(rob_head_idx),
        .redirect_valid(redirect_valid), .redirect_ready(redirect_ready), .redirect_pc(redirect_pc),
        .flush_valid(flush_valid), .flush_rob_idx(flush_rob_idx),
        .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_pc(upd_pc), .upd_target(upd_target),
        .upd_taken(upd_taken), .upd_is_jump(upd_is_jump),
        .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] pc;
        logic [31:0] target;
        logic        taken;
        logic        jump;
    } upd_rec_t;

    upd_rec_t    m_q[$];
    bit          m_pend_on;
    int          m_pend_idx, m_flush_idx, m_rec_left;
    logic [31:0] m_pend_pc;
    bit          m_flush;
    logic [31:0] m_nbr, m_nmp;

    function automatic int age(input int x, input int h);
        return ((x - h) % (1 << RW) + (1 << RW)) % (1 << RW);
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_pend_on = 0; m_pend_idx = 0; m_flush_idx = 0; m_rec_left = 0;
        m_pend_pc = '0; m_flush = 0; m_nbr = '0; m_nmp = '0;
    endtask

    task automatic model_edge();
        int ai, ap, af;
        bit acc, rec, busy, drop, keep, mp, hs;
        upd_rec_t r;
        ai   = age(int'(br_rob_idx), int'(rob_head_idx));
        ap   = age(m_pend_idx, int'(rob_head_idx));
        af   = age(m_flush_idx, int'(rob_head_idx));
        acc  = br_valid && (m_q.size() < DEPTH);
        rec  = (m_rec_left > 0);
        busy = m_pend_on || rec;
        drop = (busy && ai >= ap) || (rec && ai >= af);
        keep = acc && !drop;
        mp   = keep && br_mispredict;
        hs   = m_pend_on && redirect_ready;
        if (upd_ready && m_q.size() > 0) void'(m_q.pop_front());
        if (keep) begin
            r.pc = br_pc; r.target = br_actual_target; r.taken = br_actual_taken; r.jump = br_is_jump;
            m_q.push_back(r);
            m_nbr++;
            if (mp) m_nmp++;
        end
        m_flush = hs;
        if (hs) begin
            m_flush_idx = m_pend_idx;
            m_pend_on   = 0;
            m_rec_left  = RC;
        end else if (rec) begin
            m_rec_left--;
        end
        if (mp) begin
            m_pend_on  = 1;
            m_pend_idx = int'(br_rob_idx);
            m_pend_pc  = br_actual_target;
            m_rec_left = 0;
        end
    endtask

    task automatic model_check();
        chk("m_br_ready", 64'(br_ready), 64'(m_q.size() < DEPTH));
        chk("m_upd_valid", 64'(upd_valid), 64'(m_q.size() > 0));
        if (m_q.size() > 0) begin
            chk("m_upd_pc", 64'(upd_pc), 64'(m_q[0].pc));
            chk("m_upd_target", 64'(upd_target), 64'(m_q[0].target));
            chk("m_upd_taken", 64'(upd_taken), 64'(m_q[0].taken));
            chk("m_upd_is_jump", 64'(upd_is_jump), 64'(m_q[0].jump));
        end
        chk("m_redirect_valid", 64'(redirect_valid), 64'(m_pend_on));
        chk("m_redirect_pc", 64'(redirect_pc), m_pend_on ? 64'(m_pend_pc) : 64'(0));
        chk("m_flush_valid", 64'(flush_valid), 64'(m_flush));
        chk("m_flush_rob_idx", 64'(flush_rob_idx), 64'(m_flush_idx));
`ifdef BRANCH_STATS_EN
        chk("m_stat_branches", 64'(stat_branches), 64'(m_nbr));
        chk("m_stat_mispredicts", 64'(stat_mispredicts), 64'(m_nmp));
`else
        chk("m_stat_branches", 64'(stat_branches), 64'(0));
        chk("m_stat_mispredicts", 64'(stat_mispredicts), 64'(0));
`endif
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic drive(input bit v, input int idx, input logic [31:0] pc,
                         input bit mp, input logic [31:0] tgt);
        br_valid = v; br_rob_idx = RW'(idx); br_pc = pc; br_mispredict = mp;
        br_actual_target = tgt; br_actual_taken = 1'b1; br_is_jump = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        model_check();
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_redirect_valid", 64'(redirect_valid), 64'(0));
        chk("rst_flush_valid", 64'(flush_valid), 64'(0));
        drive(0, 0, 0, 0, 0);
        rob_head_idx = '0; redirect_ready = 1'b0; upd_ready = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_br_ready", 64'(br_ready), 64'(1));
        chk("rst_upd_valid", 64'(upd_valid), 64'(0));
        chk("rst_redirect_pc", 64'(redirect_pc), 64'(0));
        chk("rst_flush_rob_idx", 64'(flush_rob_idx), 64'(0));
        model_check();
    endtask

    typedef struct {
        int bv, idx, pc, mp, tgt, rr, ur;
        int brdy, rv, rpc, fv, fidx, uv, upc;
    } vec_t;

    vec_t vecs[12];

    initial begin
        //        bv idx pc     mp tgt    rr ur  brdy rv rpc    fv fidx uv upc
        vecs[0]  = '{1, 3, 'h100, 0, 'h104, 0, 0,  1, 0, 0,     0, 0,   1, 'h100};
        vecs[1]  = '{1, 5, 'h1F0, 1, 'h200, 0, 1,  1, 1, 'h200, 0, 0,   1, 'h1F0};
        vecs[2]  = '{0, 0, 0,     0, 0,     0, 1,  1, 1, 'h200, 0, 0,   0, 0};
        vecs[3]  = '{0, 0, 0,     0, 0,     0, 1,  1, 1, 'h200, 0, 0,   0, 0};
        vecs[4]  = '{0, 0, 0,     0, 0,     0, 1,  1, 1, 'h200, 0, 0,   0, 0};
        vecs[5]  = '{0, 0, 0,     0, 0,     1, 1,  1, 0, 0,     1, 5,   0, 0};
        vecs[6]  = '{0, 0, 0,     0, 0,     0, 1,  1, 0, 0,     0, 5,   0, 0};
        vecs[7]  = '{0, 0, 0,     0, 0,     0, 1,  1, 0, 0,     0, 5,   0, 0};
        vecs[8]  = '{1, 5, 'h300, 1, 'h400, 0, 1,  1, 1, 'h400, 0, 5,   1, 'h300};
        vecs[9]  = '{1, 2, 'h50,  1, 'h80,  0, 1,  1, 1, 'h80,  0, 5,   1, 'h50};
        vecs[10] = '{1, 7, 'h700, 0, 'h704, 0, 1,  1, 1, 'h80,  0, 5,   0, 0};
        vecs[11] = '{0, 0, 0,     0, 0,     1, 1,  1, 0, 0,     1, 2,   0, 0};

        rst = 1'b0;
        drive(0, 0, 0, 0, 0);
        rob_head_idx = '0; redirect_ready = 1'b0; upd_ready = 1'b0;
        do_reset();

        // correct branch, mispredict with held redirect, older replacement, younger drop
        for (int i = 0; i < 12; i++) begin
            drive(vecs[i].bv != 0, vecs[i].idx, 32'(vecs[i].pc), vecs[i].mp != 0, 32'(vecs[i].tgt));
            redirect_ready = (vecs[i].rr != 0);
            upd_ready      = (vecs[i].ur != 0);
            step();
            chk($sformatf("v%0d_br_ready", i), 64'(br_ready), 64'(vecs[i].brdy));
            chk($sformatf("v%0d_redirect_valid", i), 64'(redirect_valid), 64'(vecs[i].rv));
            chk($sformatf("v%0d_redirect_pc", i), 64'(redirect_pc), 64'(vecs[i].rpc));
            chk($sformatf("v%0d_flush_valid", i), 64'(flush_valid), 64'(vecs[i].fv));
            chk($sformatf("v%0d_flush_rob_idx", i), 64'(flush_rob_idx), 64'(vecs[i].fidx));
            chk($sformatf("v%0d_upd_valid", i), 64'(upd_valid), 64'(vecs[i].uv));
            if (vecs[i].uv != 0) chk($sformatf("v%0d_upd_pc", i), 64'(upd_pc), 64'(vecs[i].upc));
        end

        // older mispredict across the ROB index wrap
        do_reset();
        rob_head_idx = RW'(30); upd_ready = 1'b1;
        drive(1, 1, 'hA10, 1, 'hA00); step();
        chk("wrap_first_pc", 64'(redirect_pc), 64'('hA00));
        drive(1, 31, 'hB10, 1, 'hB00); step();
        chk("wrap_replace_pc", 64'(redirect_pc), 64'('hB00));
        drive(0, 0, 0, 0, 0); redirect_ready = 1'b1; step();
        redirect_ready = 1'b0;
        chk("wrap_flush_valid", 64'(flush_valid), 64'(1));
        chk("wrap_flush_idx", 64'(flush_rob_idx), 64'(31));
        // reset while a redirect is outstanding
        drive(1, 3, 'hC10, 1, 'hC00); step(); step(); step();
        drive(0, 0, 0, 0, 0);
        chk("midred_pending", 64'(redirect_valid), 64'(1));
        do_reset();

        // full FIFO backpressure and order
        for (int i = 0; i < 4; i++) begin
            drive(1, i, 32'('h1000 + 4 * i), 0, 0); step();
        end
        chk("full_br_ready", 64'(br_ready), 64'(0));
        drive(1, 4, 'h1010, 0, 0); upd_ready = 1'b1;
        #1;
        chk("pop_same_cycle_ready", 64'(br_ready), 64'(0));
        step();
        upd_ready = 1'b0;
        chk("after_pop_ready", 64'(br_ready), 64'(1));
        chk("after_pop_head", 64'(upd_pc), 64'('h1004));
        step();
        chk("refill_ready", 64'(br_ready), 64'(0));
        drive(0, 0, 0, 0, 0); upd_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            chk($sformatf("order_%0d", i), 64'(upd_pc), 64'('h1000 + 4 * i));
            step();
        end
        chk("drained", 64'(upd_valid), 64'(0));

        // wrong-path drop during RECOVER, then an older mispredict
        do_reset();
        upd_ready = 1'b1;
        drive(1, 10, 'hC10, 1, 'hC00); step();
        drive(0, 0, 0, 0, 0); redirect_ready = 1'b1; step();
        redirect_ready = 1'b0;
        chk("rec_flush_idx", 64'(flush_rob_idx), 64'(10));
        drive(1, 12, 'hD00, 0, 'hD04); step();
        chk("rec_drop_upd", 64'(upd_valid), 64'(0));
        chk("rec_drop_redirect", 64'(redirect_valid), 64'(0));
        drive(1, 8, 'hE10, 1, 'hE00); step();
        drive(0, 0, 0, 0, 0);
        chk("rec_older_redirect", 64'(redirect_valid), 64'(1));
        chk("rec_older_pc", 64'(redirect_pc), 64'('hE00));
`ifdef BRANCH_STATS_EN
        chk("stat_br_nodrop", 64'(stat_branches), 64'(2));
        chk("stat_mp_nodrop", 64'(stat_mispredicts), 64'(2));
`else
        chk("stat_br_tied", 64'(stat_branches), 64'(0));
        chk("stat_mp_tied", 64'(stat_mispredicts), 64'(0));
`endif

        // randomized traffic against the model
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            br_valid         = ($urandom_range(0, 9) < 6);
            br_rob_idx       = RW'($urandom);
            br_pc            = $urandom;
            br_mispredict    = ($urandom_range(0, 9) < 3);
            br_actual_taken  = 1'($urandom);
            br_actual_target = $urandom;
            br_is_jump       = 1'($urandom);
            redirect_ready   = ($urandom_range(0, 9) < 4);
            upd_ready        = ($urandom_range(0, 9) < 6);
            if ($urandom_range(0, 9) == 0) rob_head_idx = RW'($urandom);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
